// File: rtl/edge_pulse_generator.sv
// edge_pulse_generator: multi-channel synchronised edge detector that stretches edges into fixed-length pulses with sticky flags
module edge_pulse_generator #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYCLES = 1,
  parameter int RETRIGGER    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level_in,
  input  logic [2*CHANNELS-1:0] edge_select,
  input  logic [CHANNELS-1:0]   flag_clear,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic                  any_pulse_out,
  output logic [CHANNELS-1:0]   edge_flag_out
);
  localparam int cnt_w = $clog2(PULSE_CYCLES + 1);
  localparam int arm_w = $clog2(SYNC_STAGES + 2);
  localparam logic [arm_w-1:0] arm_done = arm_w'(SYNC_STAGES + 1);
  localparam logic [cnt_w-1:0] cnt_load = cnt_w'(PULSE_CYCLES);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);
  logic [CHANNELS-1:0] s, d, det;
  logic [arm_w-1:0]    arm;
  logic                armed;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = level_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else begin
        sync_q[0] <= level_in;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end
  // Detection stays masked until the synchroniser and delay flops hold real input history.
  always_ff @(posedge clock) begin
    if (reset) begin
      arm <= '0;
      d   <= '0;
    end else begin
      arm <= armed ? arm : arm + arm_w'(1);
      d   <= s;
    end
  end
  assign armed         = arm == arm_done;
  assign any_pulse_out = |pulse_out;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       mode;
    logic [cnt_w-1:0] cnt;
    logic             load;
    assign mode   = edge_select[2*g +: 2];
    assign det[g] = armed & ((mode[0] & s[g] & ~d[g]) | (mode[1] & ~s[g] & d[g]));
    assign load   = det[g] & ((cnt == '0) | (RETRIGGER != 0));
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt              <= '0;
        pulse_out[g]     <= 1'b0;
        edge_flag_out[g] <= 1'b0;
      end else begin
        if (load) begin
          cnt          <= cnt_load;
          pulse_out[g] <= 1'b1;
        end else if (cnt != '0) begin
          cnt          <= cnt - cnt_one;
          pulse_out[g] <= cnt > cnt_one;
        end
        if (det[g]) edge_flag_out[g] <= 1'b1;
        else if (flag_clear[g]) edge_flag_out[g] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_edge_pulse_generator.sv
// tb_edge_pulse_generator: directed checks over four parameterisations sharing one stimulus
module tb_edge_pulse_generator;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level_in = '0;
  logic [3:0] flag_clear = '0;
  logic [7:0] edge_select = 8'b11_10_11_01;
  logic [3:0] pa, pb, pc, pd, fa, fb, fc, fd;
  logic       aa, ab, ac, ad;
  int         total = 0;
  int         bad = 0;
  always #5 clock = ~clock;
  edge_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(0), .PULSE_CYCLES(1), .RETRIGGER(1)) u_a (
    .clock(clock), .reset(reset), .level_in(level_in), .edge_select(edge_select), .flag_clear(flag_clear),
    .pulse_out(pa), .any_pulse_out(aa), .edge_flag_out(fa));
  edge_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(3), .RETRIGGER(1)) u_b (
    .clock(clock), .reset(reset), .level_in(level_in), .edge_select(edge_select), .flag_clear(flag_clear),
    .pulse_out(pb), .any_pulse_out(ab), .edge_flag_out(fb));
  edge_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(0), .PULSE_CYCLES(4), .RETRIGGER(1)) u_c (
    .clock(clock), .reset(reset), .level_in(level_in), .edge_select(edge_select), .flag_clear(flag_clear),
    .pulse_out(pc), .any_pulse_out(ac), .edge_flag_out(fc));
  edge_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(0), .PULSE_CYCLES(4), .RETRIGGER(0)) u_d (
    .clock(clock), .reset(reset), .level_in(level_in), .edge_select(edge_select), .flag_clear(flag_clear),
    .pulse_out(pd), .any_pulse_out(ad), .edge_flag_out(fd));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    tick(3);
    chk("rst_pulse", {pa, pb, pc, pd}, 32'h0);
    chk("rst_flag", {fa, fb, fc, fd}, 32'h0);
    chk("rst_any", {aa, ab, ac, ad}, 32'h0);
    reset = 1'b0;
    tick(5);
    // single-cycle rising pulse on ch0, nothing on the fall
    level_in[0] = 1'b1;
    tick(1);
    chk("t1_pulse", pa[0], 1);
    chk("t1_any", aa, 1);
    chk("t1_flag", fa[0], 1);
    tick(1);
    chk("t1_end", pa[0], 0);
    chk("t1_any_end", aa, 0);
    tick(5);
    level_in[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t1_nofall", pa[0], 0);
    end
    tick(4);
    // both-edge mode through two sync stages, three-cycle pulses
    for (int e = 0; e < 2; e++) begin
      level_in[1] = (e == 0);
      for (int i = 0; i < 6; i++) begin
        tick(1);
        chk($sformatf("t2_pulse_e%0d_c%0d", e, i), pb[1], (i >= 2 && i <= 4));
        if (e == 0) chk($sformatf("t2_flag_c%0d", i), fb[1], (i >= 2));
      end
      tick(4);
    end
    // retrigger vs ignore, with flag set/clear interplay on ch3
    for (int i = 0; i < 8; i++) begin
      if (i == 0) level_in[3] = 1'b1;
      if (i == 1) flag_clear[3] = 1'b1;
      if (i == 2) level_in[3] = 1'b0;
      if (i == 4) flag_clear[3] = 1'b0;
      tick(1);
      chk($sformatf("t3_retrig_c%0d", i), pc[3], (i <= 5));
      chk($sformatf("t3_noretrig_c%0d", i), pd[3], (i <= 3));
      chk($sformatf("t3_any_c%0d", i), {ac, ad}, {1'b1 && (i <= 5), 1'b1 && (i <= 3)});
      if (i == 0) chk("t3_flag_set", fd[3], 1);
      if (i == 1) chk("t3_flag_clr", fd[3], 0);
      if (i == 2) chk("t5_set_wins", {fa[3], fc[3], fd[3]}, 3'b111);
      if (i == 3) chk("t5_clr_alone", {fa[3], fc[3], fd[3]}, 3'b000);
    end
    tick(6);
    // reset in the second cycle of a four-cycle pulse
    level_in[0] = 1'b1;
    tick(1);
    chk("t6_pulse", pc[0], 1);
    chk("t6_any", ac, 1);
    reset = 1'b1;
    tick(1);
    chk("t6_abort", pc, 0);
    chk("t6_any_abort", ac, 0);
    chk("t6_flags", {fa, fb, fc, fd}, 32'h0);
    // inputs high through reset must not fire after release
    level_in = 4'hF;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("t4_quiet_c%0d", i), {pa, pb, pc, pd, aa, ab, ac, ad}, 0);
      chk($sformatf("t4_noflag_c%0d", i), {fa, fb, fc, fd}, 0);
    end
    level_in[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("t4_fall_a_c%0d", i), pa[2], (i == 0));
      chk($sformatf("t4_fall_b_c%0d", i), pb[2], (i >= 2 && i <= 4));
      chk($sformatf("t4_fall_c_c%0d", i), pc[2], (i <= 3));
      chk($sformatf("t4_flag_b_c%0d", i), fb[2], (i >= 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
